// File: rtl/regfile_write_buffer.sv
// Write-back buffer in front of the register file: a small FIFO of {addr, data}
// requests drained one per cycle into a registered write port, with a RAW hazard probe.
module regfile_write_buffer #(
   parameter int noOfSelectors = 3,
   parameter int noOfBits      = 16,
   parameter int DEPTH         = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [noOfSelectors-1:0]   in_addr,
   input  logic [noOfBits-1:0]        in_data,
   input  logic                       rf_hold,
   output logic                       write_enable,
   output logic [noOfSelectors-1:0]   write_addr,
   output logic [noOfBits-1:0]        write_data,
   input  logic [noOfSelectors-1:0]   chk_addr,
   output logic                       hazard,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Handshake: a request transfers on a rising edge where in_valid && in_ready;
   // in_ready is !full and depends only on registered state, never on in_valid.

   logic [noOfSelectors-1:0] r_mem_addr [DEPTH];
   logic [noOfBits-1:0]      r_mem_data [DEPTH];

   logic [PTR_W-1:0]         r_head;
   logic [PTR_W-1:0]         r_tail;
   logic [CNT_W-1:0]         r_count;

   logic                     r_we;
   logic [noOfSelectors-1:0] r_wa;
   logic [noOfBits-1:0]      r_wd;

   logic                     w_full;
   logic                     w_empty;
   logic                     w_push;
   logic                     w_pop;
   logic [DEPTH-1:0]         w_slot_valid;
   logic [DEPTH-1:0]         w_slot_hit;
   logic                     w_out_hit;

   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == '0);

   // No pass-through when full and no bypass when empty: push and pop both
   // look only at the registered occupancy.
   assign w_push  = in_valid && !w_full;
   assign w_pop   = !w_empty && !rf_hold;

   // Payload storage carries no reset; occupancy alone decides which slots are live.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_addr[r_tail] <= in_addr;
         r_mem_data[r_tail] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + 1'b1;
         end
         if (w_pop) begin
            r_head <= r_head + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we <= 1'b0;
         r_wa <= '0;
         r_wd <= '0;
      end else if (w_pop) begin
         r_we <= 1'b1;
         r_wa <= r_mem_addr[r_head];
         r_wd <= r_mem_data[r_head];
      end else begin
         r_we <= 1'b0;
      end
   end

   // A slot is live when its distance from head (mod DEPTH) is below the occupancy.
   always_comb begin
      w_slot_valid = '0;
      w_slot_hit   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_slot_valid[i] = ({1'b0, PTR_W'(i) - r_head} < r_count);
         w_slot_hit[i]   = w_slot_valid[i] && (r_mem_addr[i] == chk_addr);
      end
   end

   assign w_out_hit    = r_we && (r_wa == chk_addr);
   assign hazard       = (|w_slot_hit) || w_out_hit;

   assign in_ready     = !w_full;
   assign full         = w_full;
   assign empty        = w_empty;
   assign count        = r_count;
   assign write_enable = r_we;
   assign write_addr   = r_wa;
   assign write_data   = r_wd;

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Bench for regfile_write_buffer: queue-based reference model, expected-write
// scoreboard, directed scenarios followed by randomized traffic.
module tb_regfile_write_buffer;

   localparam int SEL   = 3;
   localparam int BITS  = 16;
   localparam int DEPTH = 4;
   localparam int W     = SEL + BITS;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            in_valid = 1'b0;
   logic [SEL-1:0]  in_addr = '0;
   logic [BITS-1:0] in_data = '0;
   logic            rf_hold = 1'b0;
   logic [SEL-1:0]  chk_addr = '0;
   logic            in_ready;
   logic            write_enable;
   logic [SEL-1:0]  write_addr;
   logic [BITS-1:0] write_data;
   logic            hazard;
   logic [CNT_W-1:0] count;
   logic            empty;
   logic            full;

   int n_tests = 0;
   int n_fail  = 0;

   // exp_q: every accepted request, in acceptance order (scoreboard).
   // model_q: what the buffer should currently hold, plus the output stage.
   logic [W-1:0]    exp_q[$];
   logic [W-1:0]    model_q[$];
   logic            model_we = 1'b0;
   logic [SEL-1:0]  model_wa = '0;
   logic [BITS-1:0] model_wd = '0;

   regfile_write_buffer #(.noOfSelectors(SEL), .noOfBits(BITS), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
      .rf_hold(rf_hold),
      .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
      .chk_addr(chk_addr), .hazard(hazard),
      .count(count), .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic model_hazard(input logic [SEL-1:0] a);
      logic hit;
      hit = model_we && (model_wa == a);
      foreach (model_q[i]) begin
         if (model_q[i][W-1:BITS] == a) hit = 1'b1;
      end
      return hit;
   endfunction

   // Reference model: updated from the inputs seen at each rising edge.
   initial begin : model
      logic do_pop;
      logic do_push;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            model_q.delete();
            exp_q.delete();
            model_we = 1'b0;
            model_wa = '0;
            model_wd = '0;
         end else begin
            do_pop  = (model_q.size() != 0) && !rf_hold;
            do_push = in_valid && (model_q.size() < DEPTH);
            if (do_pop) begin
               {model_wa, model_wd} = model_q.pop_front();
               model_we = 1'b1;
            end else begin
               model_we = 1'b0;
            end
            if (do_push) begin
               model_q.push_back({in_addr, in_data});
               exp_q.push_back({in_addr, in_data});
            end
         end
      end
   end

   // Monitor: samples the DUT shortly after every rising edge.
   initial begin : monitor
      logic [W-1:0] e;
      forever begin
         @(posedge clk);
         #2;
         if (write_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL spurious_write: got addr %0h data %0h expected no write", write_addr, write_data);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr_order", write_addr, e[W-1:BITS]);
               check("wr_data_order", write_data, e[BITS-1:0]);
            end
         end
         check("write_enable", write_enable, model_we);
         check("write_addr",   write_addr,   model_wa);
         check("write_data",   write_data,   model_wd);
         check("count",        count,        model_q.size());
         check("in_ready",     in_ready,     model_q.size() < DEPTH);
         check("full",         full,         model_q.size() == DEPTH);
         check("empty",        empty,        model_q.size() == 0);
         check("hazard",       hazard,       model_hazard(chk_addr));
      end
   end

   task automatic cyc(input logic v, input logic [SEL-1:0] a, input logic [BITS-1:0] d,
                      input logic hold, input logic [SEL-1:0] chk);
      @(negedge clk);
      in_valid = v;
      in_addr  = a;
      in_data  = d;
      rf_hold  = hold;
      chk_addr = chk;
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0;
      rf_hold  = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      rst      = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic rdy;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_count",    count,        0);
      check("rst_in_ready", in_ready,     1);
      check("rst_empty",    empty,        1);
      check("rst_full",     full,         0);
      check("rst_we",       write_enable, 0);
      check("rst_hazard",   hazard,       0);

      // single write with immediate drain
      cyc(1'b1, 3'd3, 16'h1234, 1'b0, 3'd3);
      repeat (3) cyc(1'b0, 3'd0, 16'h0, 1'b0, 3'd3);

      // fill under hold, stall the fifth, then drain
      for (int i = 0; i < 4; i++) cyc(1'b1, SEL'(i), 16'hA000 + 16'(i), 1'b1, 3'd4);
      repeat (2) cyc(1'b1, 3'd4, 16'hA004, 1'b1, 3'd4);
      cyc(1'b1, 3'd4, 16'hA004, 1'b0, 3'd4);
      cyc(1'b1, 3'd4, 16'hA004, 1'b0, 3'd4);
      repeat (6) cyc(1'b0, 3'd0, 16'h0, 1'b0, 3'd4);

      // full queue, pop with no push, then push refills to 4
      for (int i = 0; i < 4; i++) cyc(1'b1, SEL'(i + 1), 16'hB000 + 16'(i), 1'b1, 3'd5);
      cyc(1'b1, 3'd5, 16'hB005, 1'b0, 3'd5);
      cyc(1'b1, 3'd5, 16'hB005, 1'b1, 3'd5);
      cyc(1'b0, 3'd0, 16'h0, 1'b1, 3'd5);
      repeat (6) cyc(1'b0, 3'd0, 16'h0, 1'b0, 3'd5);

      // hazard on addr 6 at slot 2, never on addr 7
      do_reset();
      cyc(1'b1, 3'd1, 16'hC001, 1'b1, 3'd6);
      cyc(1'b1, 3'd2, 16'hC002, 1'b1, 3'd6);
      cyc(1'b1, 3'd6, 16'hC006, 1'b1, 3'd6);
      cyc(1'b0, 3'd0, 16'h0, 1'b1, 3'd6);
      cyc(1'b0, 3'd0, 16'h0, 1'b1, 3'd7);
      repeat (6) cyc(1'b0, 3'd0, 16'h0, 1'b0, 3'd6);
      repeat (2) cyc(1'b0, 3'd0, 16'h0, 1'b0, 3'd7);

      // continuous push/pop, pointers wrap several times
      for (int i = 0; i < 20; i++) cyc(1'b1, SEL'($urandom), BITS'($urandom), 1'b0, SEL'($urandom));
      repeat (3) cyc(1'b0, 3'd0, 16'h0, 1'b0, 3'd0);

      // async reset mid-cycle with entries queued and a write in flight
      for (int i = 0; i < 4; i++) cyc(1'b1, 3'd2, 16'hD000 + 16'(i), 1'b1, 3'd2);
      cyc(1'b0, 3'd0, 16'h0, 1'b0, 3'd2);
      @(posedge clk);
      #3;
      check("pre_rst_we",    write_enable, 1);
      check("pre_rst_count", count,        3);
      rst = 1'b1;
      #1;
      check("async_rst_we",       write_enable, 0);
      check("async_rst_count",    count,        0);
      check("async_rst_in_ready", in_ready,     1);
      check("async_rst_empty",    empty,        1);
      check("async_rst_hazard",   hazard,       0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) cyc(1'b0, 3'd0, 16'h0, 1'b0, 3'd2);

      // randomized traffic; an unaccepted request is held unchanged
      rdy = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!(in_valid && !rdy)) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_addr  = SEL'($urandom);
            in_data  = BITS'($urandom);
         end
         rf_hold  = ($urandom_range(0, 3) == 0);
         chk_addr = SEL'($urandom);
         rdy      = in_ready;
      end
      repeat (8) cyc(1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
      check("final_scoreboard_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_write_buffer.md
# regfile_write_buffer

Write-back buffer directly upstream of the 8 x 16-bit register file. Accepts write requests (address, data) from the execute stage through a valid/ready handshake and queues them in a small FIFO. Drains one entry per cycle into the register file's write port (write_enable / write_addr / write_data) unless held off. Provides a pending-write hazard check so the read side can stall on read-after-write conflicts.

## Interface
- noOfSelectors, 3, register address width; the register file holds 2^noOfSelectors registers.
- noOfBits, 16, data width.
- DEPTH, 4, number of FIFO entries; must be a power of 2, at least 2.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high; one clock domain only.
- in_valid  in  1  upstream write request present.
- in_ready  out  1  buffer can accept; equals !full, derived only from registered state.
- in_addr  in  noOfSelectors  destination register.
- in_data  in  noOfBits  data to write.
- rf_hold  in  1  when 1, no entry is popped this cycle.
- write_enable  out  1  registered; drives the register file write enable.
- write_addr  out  noOfSelectors  registered; drives the register file write address.
- write_data  out  noOfBits  registered; drives the register file write data.
- chk_addr  in  noOfSelectors  address probed by the read side.
- hazard  out  1  combinational; 1 if chk_addr matches any valid FIFO entry, or matches write_addr while write_enable=1.
- count  out  clog2(DEPTH)+1  number of valid FIFO entries; excludes the output stage.
- empty, full  out  1  count==0, count==DEPTH.

## Operation
- Storage: DEPTH entries of {addr, data}, plus head pointer, tail pointer and count. Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- Push: when in_valid && in_ready at the clock edge, the entry is written at tail, tail increments, and count increments.
- Pop: when !empty && !rf_hold at the clock edge:
  - the head entry is loaded into write_addr/write_data;
  - write_enable goes to 1;
  - head increments and count decrements.
- Otherwise write_enable goes to 0. write_addr and write_data hold their last values.
- Simultaneous push and pop when not full: both happen and count is unchanged.
  - When count==1, the popped entry is the old head. The new entry stays queued.
- Full: in_ready=0, so no push is possible, even if a pop happens in the same cycle (no pass-through).
- Empty with in_valid=1: the entry is stored. It cannot be popped in the same cycle (no bypass).
- Ordering is strict FIFO. Repeated writes to the same address are not coalesced, so the last one pushed is the last one written.
- hazard ignores in_valid/in_addr in the current cycle. Entries are checked by valid slot only, so stale slots never match.
- Reset, asynchronous, including mid-operation:
  - count=0, head=0, tail=0;
  - write_enable=0, write_addr=0, write_data=0;
  - in_ready=1, empty=1, full=0, hazard=0.
  - All queued writes are discarded. Storage contents need not be cleared.

## Timing
- Latency: a request accepted at edge N is at the head at the earliest after N. With rf_hold=0 and an empty queue, write_enable=1 from edge N+1 to edge N+2, and the register file captures the write at edge N+2.
- Throughput: one push and one pop per cycle sustained.
- in_ready, empty, full and count change only at clock edges or on reset.
- hazard is valid combinationally in the same cycle as chk_addr. It stays asserted until the cycle after the matching write_enable pulse has ended.
- rf_hold takes effect at the edge where it is sampled high. The queue is frozen and write_enable drops to 0 at that edge.

## Test plan
- Reset, then push {addr 3, data 0x1234}, rf_hold=0:
  - write_enable=1 exactly one cycle later, with write_addr=3 and write_data=0x1234;
  - count returns to 0.
- Hold rf_hold=1 and push 5 entries (addr 0..4, data 0xA000+i):
  - the first 4 are accepted, full=1, in_ready=0, and the 5th is stalled;
  - release rf_hold: writes drain in order 0,1,2,3 on consecutive cycles, then the 5th entry follows.
- Full queue, in_valid=1 and rf_hold released in the same cycle: the pop happens, no push that cycle; in_ready=1 next cycle, the push is accepted and count stays 4.
- Queue holds addr 6 at slot 2, chk_addr=6 -> hazard=1; after addr 6 drains and its write_enable cycle ends -> hazard=0; chk_addr=7 (never queued) -> hazard=0 throughout.
- Continuous push/pop of 20 entries: pointers wrap past DEPTH, data out equals data in order, and count holds 1.
- Assert rst asynchronously mid-clock with 3 entries queued and write_enable=1: write_enable=0 and count=0 immediately, in_ready=1, and no queued write ever appears afterwards.
